// File: rtl/scariv_regwrite_arbiter_if.sv
// Writeback bus between the requesters and the register-write arbiter.
//   i_req_valid/i_req_rnid/i_req_data : per-requester write request
//   o_req_ready                       : per-requester accept (registered state only)
//   o_wr_valid/o_wr_rnid/o_wr_data    : physical register write ports
//   o_busy                            : anything queued or being written
// slave  : arbiter side.  master : requester / register-file side.
interface scariv_regwrite_arbiter_if #(
    parameter int REQ_NUM      = 4,
    parameter int WR_PORT_SIZE = 2,
    parameter int RNID_W       = 7,
    parameter int WIDTH        = 64
);
    logic [REQ_NUM-1:0]                   i_req_valid;
    logic [REQ_NUM-1:0][RNID_W-1:0]       i_req_rnid;
    logic [REQ_NUM-1:0][WIDTH-1:0]        i_req_data;
    logic [REQ_NUM-1:0]                   o_req_ready;
    logic [WR_PORT_SIZE-1:0]              o_wr_valid;
    logic [WR_PORT_SIZE-1:0][RNID_W-1:0]  o_wr_rnid;
    logic [WR_PORT_SIZE-1:0][WIDTH-1:0]   o_wr_data;
    logic                                 o_busy;

    modport slave (
        input  i_req_valid, i_req_rnid, i_req_data,
        output o_req_ready, o_wr_valid, o_wr_rnid, o_wr_data, o_busy
    );

    modport master (
        output i_req_valid, i_req_rnid, i_req_data,
        input  o_req_ready, o_wr_valid, o_wr_rnid, o_wr_data, o_busy
    );
endinterface

// File: rtl/scariv_regwrite_arbiter.sv
// Register writeback arbiter: each requester owns a 2-entry FIFO; every cycle
// up to WR_PORT_SIZE non-empty FIFOs are granted in round-robin order and their
// heads are registered onto the write ports (one entry per FIFO per cycle).
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)      : request inputs, ready, write ports, busy
module scariv_regwrite_arbiter #(
    parameter int REQ_NUM      = 4,
    parameter int WR_PORT_SIZE = 2,
    parameter int RNID_W       = 7,
    parameter int WIDTH        = 64,
    parameter int DROP_RNID0   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    scariv_regwrite_arbiter_if.slave bus
);
    localparam int RR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int PORT_W = (WR_PORT_SIZE > 1) ? $clog2(WR_PORT_SIZE) : 1;

    logic [REQ_NUM-1:0][1:0][RNID_W-1:0] ent_rnid_q, ent_rnid_d;
    logic [REQ_NUM-1:0][1:0][WIDTH-1:0]  ent_data_q, ent_data_d;
    logic [REQ_NUM-1:0][1:0]             cnt_q, cnt_d;
    logic [REQ_NUM-1:0]                  wptr_q, wptr_d;
    logic [REQ_NUM-1:0]                  rptr_q, rptr_d;
    logic [RR_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [WR_PORT_SIZE-1:0]             wr_valid_q, wr_valid_d;
    logic [WR_PORT_SIZE-1:0][RNID_W-1:0] wr_rnid_q, wr_rnid_d;
    logic [WR_PORT_SIZE-1:0][WIDTH-1:0]  wr_data_q, wr_data_d;

    logic [REQ_NUM-1:0] ready;
    logic [REQ_NUM-1:0] grant;
    logic [REQ_NUM-1:0] accept;
    logic [RR_W:0]      sum;
    logic [RR_W-1:0]    idx;
    logic [PORT_W:0]    n_grant;
    logic [PORT_W-1:0]  port;

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            ready[i] = (cnt_q[i] != 2'd2);
        end
    end

    // Round-robin grant: walk rr_ptr, rr_ptr+1, ... (mod REQ_NUM) and hand
    // the first WR_PORT_SIZE non-empty FIFOs to ports 0, 1, ... in that order.
    always_comb begin
        grant      = '0;
        wr_valid_d = '0;
        wr_rnid_d  = '0;
        wr_data_d  = '0;
        rr_ptr_d   = rr_ptr_q;
        n_grant    = '0;
        sum        = '0;
        idx        = '0;
        port       = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
            if (sum >= (RR_W+1)'(REQ_NUM)) begin
                sum = sum - (RR_W+1)'(REQ_NUM);
            end
            idx  = sum[RR_W-1:0];
            port = n_grant[PORT_W-1:0];
            if (cnt_q[idx] != 2'd0 && n_grant < (PORT_W+1)'(WR_PORT_SIZE)) begin
                grant[idx]       = 1'b1;
                wr_valid_d[port] = 1'b1;
                wr_rnid_d[port]  = ent_rnid_q[idx][rptr_q[idx]];
                wr_data_d[port]  = ent_data_q[idx][rptr_q[idx]];
                n_grant          = n_grant + 1'b1;
                rr_ptr_d         = (idx == RR_W'(REQ_NUM - 1)) ? '0 : idx + RR_W'(1);
            end
        end
    end

    // FIFO bookkeeping. A free slot always sits at wptr when ready is high,
    // including count=1 with a same-cycle dequeue, so enqueue never clobbers
    // the head being read out.
    always_comb begin
        ent_rnid_d = ent_rnid_q;
        ent_data_d = ent_data_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        accept     = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            // rnid 0 is handshaken (ready stays up) but never stored.
            accept[i] = bus.i_req_valid[i] && ready[i] &&
                        !((DROP_RNID0 != 0) && (bus.i_req_rnid[i] == '0));
            if (accept[i]) begin
                ent_rnid_d[i][wptr_q[i]] = bus.i_req_rnid[i];
                ent_data_d[i][wptr_q[i]] = bus.i_req_data[i];
                wptr_d[i]                = ~wptr_q[i];
            end
            if (grant[i]) begin
                rptr_d[i] = ~rptr_q[i];
            end
            if (accept[i] && !grant[i]) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (grant[i] && !accept[i]) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ent_rnid_q <= '0;
            ent_data_q <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rr_ptr_q   <= '0;
            wr_valid_q <= '0;
            wr_rnid_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            ent_rnid_q <= ent_rnid_d;
            ent_data_q <= ent_data_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_rnid_q  <= wr_rnid_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        bus.o_busy = |wr_valid_q;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (cnt_q[i] != 2'd0) begin
                bus.o_busy = 1'b1;
            end
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_wr_valid  = wr_valid_q;
    assign bus.o_wr_rnid   = wr_rnid_q;
    assign bus.o_wr_data   = wr_data_q;

`ifndef SYNTHESIS
    // Two ports writing the same physical register in one cycle is a
    // rename bug upstream; flag it loudly.
    always @(posedge i_clk) begin
        if (i_reset_n) begin
            for (int a = 0; a < WR_PORT_SIZE; a++) begin
                for (int b = a + 1; b < WR_PORT_SIZE; b++) begin
                    if (wr_valid_q[a] && wr_valid_q[b]) begin
                        assert (wr_rnid_q[a] != wr_rnid_q[b]);
                    end
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_scariv_regwrite_arbiter.sv
module tb_scariv_regwrite_arbiter;
    localparam int REQ = 4;
    localparam int WP  = 2;
    localparam int RW  = 7;
    localparam int DW  = 64;

    typedef struct {
        logic [RW-1:0] rnid;
        logic [DW-1:0] data;
    } ent_t;

    logic i_clk;
    logic i_reset_n;

    scariv_regwrite_arbiter_if #(.REQ_NUM(REQ), .WR_PORT_SIZE(WP), .RNID_W(RW), .WIDTH(DW)) bif ();
    scariv_regwrite_arbiter_if #(.REQ_NUM(REQ), .WR_PORT_SIZE(1), .RNID_W(RW), .WIDTH(DW)) bif1 ();

    scariv_regwrite_arbiter #(.REQ_NUM(REQ), .WR_PORT_SIZE(WP), .RNID_W(RW), .WIDTH(DW), .DROP_RNID0(1)) u_dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bif)
    );
    scariv_regwrite_arbiter #(.REQ_NUM(REQ), .WR_PORT_SIZE(1), .RNID_W(RW), .WIDTH(DW), .DROP_RNID0(1)) u_dut1 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bif1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one queue per requester, round-robin start index,
    // and the write-port contents expected after the coming edge.
    ent_t          mq[REQ][$];
    int            m_rr;
    logic          ev[WP];
    logic [RW-1:0] er[WP];
    logic [DW-1:0] ed[WP];

    // Requester side: a pending request is held until accepted.
    logic          pend[REQ];
    logic [RW-1:0] p_rnid[REQ];
    logic [DW-1:0] p_data[REQ];

    int n_rn0, n_rn9;
    logic saw_nr2;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < REQ; i++) begin
            mq[i].delete();
            pend[i] = 1'b0;
        end
        m_rr = 0;
        for (int p = 0; p < WP; p++) begin
            ev[p] = 1'b0; er[p] = '0; ed[p] = '0;
        end
    endtask

    task automatic model_step();
        bit rdy[REQ];
        int ng;
        int last;
        int idx;
        ng = 0;
        last = -1;
        for (int i = 0; i < REQ; i++) rdy[i] = (mq[i].size() < 2);
        for (int p = 0; p < WP; p++) begin
            ev[p] = 1'b0; er[p] = '0; ed[p] = '0;
        end
        for (int k = 0; k < REQ; k++) begin
            idx = (m_rr + k) % REQ;
            if (ng < WP && mq[idx].size() > 0) begin
                ev[ng] = 1'b1;
                er[ng] = mq[idx][0].rnid;
                ed[ng] = mq[idx][0].data;
                void'(mq[idx].pop_front());
                ng++;
                last = idx;
            end
        end
        if (last >= 0) m_rr = (last + 1) % REQ;
        for (int i = 0; i < REQ; i++) begin
            if (pend[i] && rdy[i] && p_rnid[i] != '0) begin
                mq[i].push_back('{rnid: p_rnid[i], data: p_data[i]});
            end
        end
    endtask

    // Called just after a falling edge: drive, check ready, advance one clock,
    // then check the write ports and busy against the model.
    task automatic drive_cycle();
        bit acc[REQ];
        bit busy_exp;
        for (int i = 0; i < REQ; i++) begin
            bif.i_req_valid[i] = pend[i];
            bif.i_req_rnid[i]  = p_rnid[i];
            bif.i_req_data[i]  = p_data[i];
            acc[i] = pend[i] && (mq[i].size() < 2);
        end
        #1;
        for (int i = 0; i < REQ; i++) begin
            check($sformatf("ready%0d", i), bif.o_req_ready[i], (mq[i].size() < 2));
        end
        if (bif.o_req_ready[2] === 1'b0) saw_nr2 = 1'b1;
        model_step();
        @(posedge i_clk);
        @(negedge i_clk);
        busy_exp = 1'b0;
        for (int i = 0; i < REQ; i++) if (mq[i].size() > 0) busy_exp = 1'b1;
        for (int p = 0; p < WP; p++) begin
            check($sformatf("wr_valid%0d", p), bif.o_wr_valid[p], ev[p]);
            check($sformatf("wr_rnid%0d", p), bif.o_wr_rnid[p], er[p]);
            check($sformatf("wr_data%0d", p), bif.o_wr_data[p], ed[p]);
            if (ev[p]) busy_exp = 1'b1;
            if (bif.o_wr_valid[p] && bif.o_wr_rnid[p] == 0) n_rn0++;
            if (bif.o_wr_valid[p] && bif.o_wr_rnid[p] == 9) n_rn9++;
        end
        check("busy", bif.o_busy, busy_exp);
        for (int i = 0; i < REQ; i++) if (acc[i]) pend[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] rn, input logic [DW-1:0] d);
        pend[i] = 1'b1; p_rnid[i] = rn; p_data[i] = d;
    endtask

    task automatic do_reset();
        bif.i_req_valid  = '0;
        bif1.i_req_valid = '0;
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_wr_valid", bif.o_wr_valid, '0);
        check("rst_wr_rnid", bif.o_wr_rnid, '0);
        check("rst_wr_data", bif.o_wr_data, '0);
        check("rst_ready", bif.o_req_ready, 4'hf);
        check("rst_busy", bif.o_busy, 1'b0);
        check("rst_dut1_valid", bif1.o_wr_valid, '0);
        model_reset();
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_reset_n = 1'b1;
        bif.i_req_valid = '0; bif.i_req_rnid = '0; bif.i_req_data = '0;
        bif1.i_req_valid = '0; bif1.i_req_rnid = '0; bif1.i_req_data = '0;
        for (int i = 0; i < REQ; i++) begin
            pend[i] = 1'b0; p_rnid[i] = '0; p_data[i] = '0;
        end
        n_rn0 = 0; n_rn9 = 0; saw_nr2 = 1'b0;
        do_reset();

        // Single write: visible two cycles after the handshake, port 0 only.
        set_req(0, 7'd5, 64'hAA);
        drive_cycle();
        drive_cycle();
        check("single_valid0", bif.o_wr_valid[0], 1'b1);
        check("single_rnid0", bif.o_wr_rnid[0], 7'd5);
        check("single_data0", bif.o_wr_data[0], 64'hAA);
        check("single_valid1", bif.o_wr_valid[1], 1'b0);

        // Contention: four requesters at once from rr_ptr 0.
        do_reset();
        for (int i = 0; i < REQ; i++) set_req(i, RW'(i + 1), DW'(64'h100 + i));
        drive_cycle();
        drive_cycle();
        check("cont_c2_rnid0", bif.o_wr_rnid[0], 7'd1);
        check("cont_c2_rnid1", bif.o_wr_rnid[1], 7'd2);
        check("cont_c2_valid", bif.o_wr_valid, 2'b11);
        drive_cycle();
        check("cont_c3_rnid0", bif.o_wr_rnid[0], 7'd3);
        check("cont_c3_rnid1", bif.o_wr_rnid[1], 7'd4);
        drive_cycle();
        check("cont_idle_busy", bif.o_busy, 1'b0);

        // rnid 0 is swallowed; only rnid 9 reaches a port.
        do_reset();
        n_rn0 = 0; n_rn9 = 0;
        set_req(1, 7'd0, 64'hDEAD);
        drive_cycle();
        check("drop_ready1_a", bif.o_req_ready[1], 1'b1);
        set_req(1, 7'd9, 64'hBEEF);
        drive_cycle();
        check("drop_ready1_b", bif.o_req_ready[1], 1'b1);
        for (int c = 0; c < 3; c++) drive_cycle();
        check("drop_seen_rnid0", n_rn0, 0);
        check("drop_seen_rnid9", n_rn9, 1);

        // Backpressure: everyone saturating, req2 must fill up; then drain.
        do_reset();
        saw_nr2 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < REQ; i++) begin
                if (!pend[i]) set_req(i, RW'(((c % 32) << 2) | i) | 7'h04, DW'({$urandom, $urandom}));
            end
            drive_cycle();
        end
        check("bp_ready2_low_seen", saw_nr2, 1'b1);
        for (int i = 0; i < REQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 6; c++) drive_cycle();

        // Fairness with one write port: req0/req1 alternate.
        do_reset();
        bif1.i_req_rnid[0] = 7'd4;
        bif1.i_req_rnid[1] = 7'd5;
        bif1.i_req_data[0] = 64'h40;
        bif1.i_req_data[1] = 64'h50;
        bif1.i_req_valid   = 4'b0011;
        for (int c = 1; c <= 10; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (c >= 2) begin
                check($sformatf("rr_valid_c%0d", c), bif1.o_wr_valid[0], 1'b1);
                check($sformatf("rr_rnid_c%0d", c), bif1.o_wr_rnid[0], (c % 2 == 0) ? 7'd4 : 7'd5);
            end
        end
        bif1.i_req_valid = '0;

        // Reset with three FIFOs holding entries and writes in flight.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) set_req(i, RW'(((c + 1) << 2) | i), DW'(64'h300 + c * 4 + i));
            drive_cycle();
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive_cycle();
            check("post_rst_no_write", bif.o_wr_valid, '0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < REQ; i++) begin
                if (!pend[i] && $urandom_range(3) != 0) begin
                    set_req(i, RW'((($urandom % 32) << 2) | i), DW'({$urandom, $urandom}));
                end
            end
            drive_cycle();
        end
        for (int i = 0; i < REQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 6; c++) drive_cycle();
        check("final_idle", bif.o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/scariv_regwrite_arbiter.md
SCARIV_REGWRITE_ARBITER -- requirements
Module: scariv_regwrite_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4, meaning the number of writeback requesters.
REQ-002 SHALL have parameter WR_PORT_SIZE, default 2, meaning the number of physical-register write ports driven (WR_PORT_SIZE <= REQ_NUM).
REQ-003 SHALL have parameter RNID_W, default 7, meaning the physical register id width.
REQ-004 SHALL have parameter WIDTH, default 64, meaning the data width.
REQ-005 SHALL have parameter DROP_RNID0, default 1, meaning that writes to rnid 0 (hardwired X0) are discarded.
REQ-006 SHALL have ports:
- i_clk  in  1  clock; single clock domain.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  [REQ_NUM]  requester write valid.
- i_req_rnid  in  [REQ_NUM][RNID_W]  destination rnid.
- i_req_data  in  [REQ_NUM][WIDTH]  write data.
- o_req_ready  out  [REQ_NUM]  requester may hand over a write this cycle.
- o_wr_valid  out  [WR_PORT_SIZE]  write-port valid.
- o_wr_rnid  out  [WR_PORT_SIZE][RNID_W]  write-port rnid.
- o_wr_data  out  [WR_PORT_SIZE][WIDTH]  write-port data.
- o_busy  out  1  any queue non-empty or any o_wr_valid set.

Function
REQ-007 SHALL provide one 2-entry FIFO per requester, with per-FIFO count 0..2.
REQ-008 SHALL set o_req_ready[i] = (count[i] < 2), derived from registered state only; it has no combinational path from i_req_valid.
REQ-009 SHALL enqueue on a rising clock edge when i_req_valid[i] && o_req_ready[i].
- Valid without ready is ignored; the requester must hold its request.
REQ-010 When DROP_RNID0=1, a handshaken write with rnid 0 SHALL be accepted and discarded: no enqueue, no count change.
REQ-011 Each cycle, SHALL grant up to WR_PORT_SIZE non-empty FIFOs.
- Search order is round-robin: start at pointer rr_ptr, ascending, wrapping modulo REQ_NUM.
- At most one entry per FIFO per cycle.
- Grant k drives write port k.
REQ-012 Granted FIFO heads SHALL dequeue on the same edge that registers them into o_wr_valid/o_wr_rnid/o_wr_data.
- Write ports therefore present data exactly one cycle after grant.
- Minimum latency, handshake to o_wr_valid, is 2 cycles.
REQ-013 Unused write ports SHALL have o_wr_valid=0; o_wr_rnid and o_wr_data are then 0.
REQ-014 After a cycle with at least one grant, rr_ptr SHALL become (last granted index + 1) mod REQ_NUM; with no grant, rr_ptr is unchanged.
REQ-015 Simultaneous enqueue and dequeue on the same FIFO SHALL leave count unchanged and preserve FIFO order.
- This includes count=1 (head dequeued, new entry becomes head).
- At count=2, ready is 0, so no enqueue can occur.
REQ-016 Entries from one requester SHALL reach the write ports in acceptance order, never two in one cycle.
REQ-017 Any requester with a non-empty FIFO SHALL be granted within ceil(REQ_NUM/WR_PORT_SIZE) cycles (starvation-free).
REQ-018 Under SIMULATION, SHALL assert that no two o_wr_valid ports carry the same rnid in the same cycle.
REQ-019 o_busy SHALL be the OR of all (count != 0) and all o_wr_valid.

Reset
REQ-020 On i_reset_n low, SHALL asynchronously clear all counts, FIFO pointers, rr_ptr (to 0), o_wr_valid, o_wr_rnid and o_wr_data.
- o_req_ready then reads all-ones; o_busy reads 0.
REQ-021 Reset mid-operation SHALL discard all queued and in-flight writes; no write appears on o_wr_valid after reset deasserts unless newly handshaken.

Verification
REQ-022 Single write: req0 valid, rnid=5, data=0xAA at cycle 0.
- Required: o_wr_valid[0]=1, rnid=5, data=0xAA at cycle 2.
- All other o_wr_valid are 0; rr_ptr=1.
REQ-023 Contention: all 4 requesters valid in cycle 0 (rnid 1..4), rr_ptr=0.
- Required cycle 2: ports carry rnid 1, 2.
- Required cycle 3: ports carry rnid 3, 4.
- Then o_busy=0.
REQ-024 Backpressure: req2 valid every cycle, with write ports never granting req2 for 2 cycles (others saturating).
- Required: o_req_ready[2]=0 once count=2.
- Order is preserved on drain.
REQ-025 Round-robin fairness: requesters 0 and 1 continuously valid, WR_PORT_SIZE=1.
- Required: grants alternate 0,1,0,1; no requester waits more than 4 cycles.
REQ-026 rnid 0 drop: req1 writes rnid=0 then rnid=9.
- Required: only rnid=9 appears on a port; o_req_ready[1] stays 1.
REQ-027 Reset mid-operation: reset asserted with 3 FIFOs non-empty.
- Required: o_wr_valid=0 immediately, all ready=1, no stale write after release.
